// File: rtl/cpu_pkg.sv
// Shared arbiter types: FSM state encoding, grant-owner encoding and default widths.
package cpu_pkg;
   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 16;
   localparam int MEM_LAT_DEF = 2;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_owner_e;

   function automatic gnt_owner_e other_owner(input gnt_owner_e owner);
      return (owner == GNT_IF) ? GNT_DM : GNT_IF;
   endfunction
endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin pick between the fetch and data requesters.
module arb_rr_select
   import cpu_pkg::*;
(
   input  logic       if_req,
   input  logic       dm_req,
   input  gnt_owner_e last_gnt,
   output gnt_owner_e winner
);

   // A contested request goes to whoever did not win last time.
   always_comb begin
      winner = GNT_DM;
      case ({if_req, dm_req})
         2'b11:   winner = other_owner(last_gnt);
         2'b10:   winner = GNT_IF;
         2'b01:   winner = GNT_DM;
         default: winner = GNT_DM;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter with a fixed-latency access FSM.
// Build macro MEM_ARB_FIXED_PRIO_EN: dm always wins contested requests, no rr pointer.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

   arb_state_e        state_q,     state_d;
   gnt_owner_e        owner_q,     owner_d;
   logic              we_q,        we_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              mem_en_q,    mem_en_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q,     rdata_d;
   logic              if_ack_q,    if_ack_d;
   logic              dm_ack_q,    dm_ack_d;
   logic              busy_q,      busy_d;
   gnt_owner_e        winner;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign winner = dm_req ? GNT_DM : GNT_IF;
`else
   gnt_owner_e        last_gnt_q,  last_gnt_d;

   arb_rr_select u_rr_select (
      .if_req   (if_req),
      .dm_req   (dm_req),
      .last_gnt (last_gnt_q),
      .winner   (winner)
   );
`endif

   // Next-state and registered-output logic; mem_addr/mem_wdata double as the operand latch.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      busy_d      = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_gnt_d  = last_gnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               state_d  = ST_ISSUE;
               owner_d  = winner;
               mem_en_d = 1'b1;
               if (winner == GNT_DM) begin
                  we_d        = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
               end else begin
                  we_d        = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = {DATA_W{1'b0}};
               end
               mem_we_d = we_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
               last_gnt_d = winner;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d = LAT_M1;
            if (MEM_LAT == 1) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!we_q) begin
               rdata_d = mem_rdata;
            end else begin
               rdata_d = rdata_q;
            end
            if (owner_q == GNT_IF) begin
               if_ack_d = 1'b1;
            end else begin
               dm_ack_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= GNT_IF;
         we_q        <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         rdata_q     <= {DATA_W{1'b0}};
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         // Last winner = if, so dm is favoured after reset.
         last_gnt_q  <= GNT_IF;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         busy_q      <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_gnt_q  <= last_gnt_d;
`endif
      end
   end

   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign rdata     = rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter: a MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          preload = 1'b1;

   logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          if_ack, dm_ack, mem_en, mem_we, busy;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic          if_req_1 = 1'b0, dm_req_1 = 1'b0, dm_we_1 = 1'b0;
   logic [AW-1:0] if_addr_1 = '0, dm_addr_1 = '0;
   logic [DW-1:0] dm_wdata_1 = '0;
   logic          if_ack_1, dm_ack_1, mem_en_1, mem_we_1, busy_1;
   logic [DW-1:0] rdata_1, mem_wdata_1, mem_rdata_1;
   logic [AW-1:0] mem_addr_1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req_1), .if_addr(if_addr_1), .if_ack(if_ack_1),
      .dm_req(dm_req_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1), .dm_ack(dm_ack_1),
      .rdata(rdata_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
      .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
   );

   // Memory model: data valid exactly one cycle, MEM_LAT cycles after the mem_en cycle.
   logic [DW-1:0] mem [256];
   int            pend0 = 0, pend1 = 0;
   logic [DW-1:0] pdat0 = '0, pdat1 = '0;

   always @(posedge clk) begin
      if (preload) begin
         mem[8'h10] <= 16'hBEEF;
         mem[8'h20] <= 16'h0000;
         mem[8'h30] <= 16'h5A5A;
         mem[8'hFF] <= 16'h0F0F;
         mem[8'h00] <= 16'h8001;
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always @(posedge clk) begin
      if (mem_en) begin
         pend0 <= 2;
         pdat0 <= mem[mem_addr];
      end else if (pend0 != 0) begin
         pend0 <= pend0 - 1;
      end
      if (mem_en_1) begin
         pend1 <= 1;
         pdat1 <= mem_we_1 ? mem_wdata_1 : mem[mem_addr_1];
      end else if (pend1 != 0) begin
         pend1 <= pend1 - 1;
      end
   end

   assign mem_rdata   = (pend0 == 1) ? pdat0 : 16'hDEAD;
   assign mem_rdata_1 = (pend1 == 1) ? pdat1 : 16'hDEAD;

   typedef struct packed {
      logic          is_dm;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_if_ack"},    32'(if_ack),    32'd0);
      chk({tag, "_dm_ack"},    32'(dm_ack),    32'd0);
      chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
      chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_rdata"},     32'(rdata),     32'd0);
   endtask

   // One access on the MEM_LAT=2 instance; req is held until the ack is seen.
   task automatic run_vec(input int idx, input vec_t v);
      int            ack_cyc = -1, en_cyc = -1, en_cnt = 0, bad = 0;
      logic [AW-1:0] en_addr = '0;
      logic [DW-1:0] en_wdata = '0;
      logic          en_we = 1'b0;
      string         p;
      p = $sformatf("v%0d", idx);
      @(negedge clk);
      if (v.is_dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int cyc = 1; cyc <= 12 && ack_cyc < 0; cyc++) begin
         @(negedge clk);
         if (mem_en) begin
            en_cnt++; en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
         end
         if (mem_we && !mem_en) bad++;
         if (v.is_dm ? if_ack : dm_ack) bad++;
         if (v.is_dm ? dm_ack : if_ack) begin
            ack_cyc = cyc;
            if_req = 1'b0; dm_req = 1'b0;
            chk({p, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
            chk({p, "_busy_at_ack"}, 32'(busy), 32'd0);
         end
      end
      if_req = 1'b0; dm_req = 1'b0;
      chk({p, "_ack_cycle"}, 32'(ack_cyc), 32'd4);
      chk({p, "_en_count"}, 32'(en_cnt), 32'd1);
      chk({p, "_en_cycle"}, 32'(en_cyc), 32'd1);
      chk({p, "_mem_addr"}, 32'(en_addr), 32'(v.addr));
      chk({p, "_mem_we"}, 32'(en_we), 32'(v.we));
      if (v.we) chk({p, "_mem_wdata"}, 32'(en_wdata), 32'(v.wdata));
      chk({p, "_stray"}, 32'(bad), 32'd0);
      @(negedge clk);
      chk({p, "_idle_after"}, {29'd0, mem_en, if_ack | dm_ack, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int            n_ack, both, acks, dacks, ens, ack_c, busy_c;
      logic          got_dm [4];
      logic [DW-1:0] got_rd [4];
      int            got_cyc [4];
      logic          exp_dm;

      vecs[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b1, 8'h20, 16'h1234, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h1234};
      vecs[3] = '{1'b0, 1'b0, 8'h30, 16'h0000, 16'h5A5A};
      vecs[4] = '{1'b1, 1'b1, 8'h10, 16'hCAFE, 16'h5A5A};
      vecs[5] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hCAFE};
      vecs[6] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'h0F0F};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h8001};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      preload = 1'b0;
      rst = 1'b0;

      // MEM_LAT=1 instance: ack three cycles after the sampled req, busy only two cycles.
      @(negedge clk);
      if_req_1 = 1'b1; if_addr_1 = 8'h10;
      ack_c = -1; ens = -1; busy_c = 0; dacks = 0;
      for (int cyc = 1; cyc <= 10 && ack_c < 0; cyc++) begin
         @(negedge clk);
         if (mem_en_1) begin
            ens = cyc;
            chk("lat1_mem_addr", 32'(mem_addr_1), 32'h10);
            chk("lat1_mem_we", 32'(mem_we_1), 32'd0);
         end
         if (busy_1) busy_c++;
         if (dm_ack_1) dacks++;
         if (if_ack_1) begin
            ack_c = cyc;
            if_req_1 = 1'b0;
            chk("lat1_rdata", 32'(rdata_1), 32'hBEEF);
         end
      end
      if_req_1 = 1'b0;
      chk("lat1_en_cycle", 32'(ens), 32'd1);
      chk("lat1_ack_cycle", 32'(ack_c), 32'd3);
      chk("lat1_busy_cycles", 32'(busy_c), 32'd2);
      chk("lat1_dm_ack", 32'(dacks), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Early drop: fetch req released while in WAIT still completes exactly once.
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'h30;
      acks = 0; dacks = 0; ens = 0; ack_c = -1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin
            chk("drop_busy_in_wait", 32'(busy), 32'd1);
            if_req = 1'b0;
         end
         if (mem_en) ens++;
         if (dm_ack) dacks++;
         if (if_ack) begin
            acks++; ack_c = cyc;
            chk("drop_rdata", 32'(rdata), 32'h5A5A);
         end
      end
      chk("drop_if_acks", 32'(acks), 32'd1);
      chk("drop_ack_cycle", 32'(ack_c), 32'd4);
      chk("drop_mem_en_count", 32'(ens), 32'd1);
      chk("drop_dm_acks", 32'(dacks), 32'd0);

      // Contested requests, both held continuously from a fresh reset.
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         got_dm[k] = 1'bx; got_rd[k] = 'x; got_cyc[k] = -1;
      end
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'h00; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30;
      n_ack = 0; both = 0;
      for (int cyc = 1; cyc <= 40 && n_ack < 4; cyc++) begin
         @(negedge clk);
         if (if_ack && dm_ack) both++;
         if (if_ack || dm_ack) begin
            got_dm[n_ack] = dm_ack; got_rd[n_ack] = rdata; got_cyc[n_ack] = cyc;
            n_ack++;
         end
      end
      if_req = 1'b0; dm_req = 1'b0;
      chk("rr_ack_count", 32'(n_ack), 32'd4);
      chk("rr_both_acks", 32'(both), 32'd0);
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_dm = 1'b1;
`else
         exp_dm = ((k % 2) == 0);
`endif
         chk($sformatf("rr_owner%0d", k), 32'(got_dm[k]), 32'(exp_dm));
         chk($sformatf("rr_rdata%0d", k), 32'(got_rd[k]), exp_dm ? 32'h5A5A : 32'h8001);
         chk($sformatf("rr_ack_cycle%0d", k), 32'(got_cyc[k]), 32'(4 * (k + 1)));
      end
      repeat (2) @(negedge clk);

      // Reset in WAIT abandons the load; its late memory data must not surface.
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
      repeat (2) @(negedge clk);
      chk("rstmid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1; dm_req = 1'b0;
      @(negedge clk);
      check_reset_outputs("rstmid");
      rst = 1'b0;
      acks = 0; ens = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (if_ack || dm_ack) acks++;
         if (mem_en) ens++;
      end
      chk("rstmid_no_ack", 32'(acks), 32'd0);
      chk("rstmid_no_access", 32'(ens), 32'd0);
      chk("rstmid_rdata_kept", 32'(rdata), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
